// File: rtl/bp_cacc_csr_ctrl.sv
// CSR front end for the accelerator tile: decodes uncached I/O commands into a small register file,
// launches the datapath and tracks busy/done. Define BP_CACC_CSR_CYCLE_COUNT_EN for the busy-cycle counter at index 8.
module bp_cacc_csr_ctrl #(
  parameter int paddr_width_p   = 40,
  parameter int data_width_p    = 64,
  parameter int len_width_p     = 16,
  parameter int payload_width_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_ready_o,
  input  logic [3:0]                 io_cmd_type_i,
  input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
  input  logic [2:0]                 io_cmd_size_i,
  input  logic [data_width_p-1:0]    io_cmd_data_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  output logic                       io_resp_v_o,
  input  logic                       io_resp_yumi_i,
  output logic [3:0]                 io_resp_type_o,
  output logic [paddr_width_p-1:0]   io_resp_addr_o,
  output logic [2:0]                 io_resp_size_o,
  output logic [data_width_p-1:0]    io_resp_data_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic                       start_o,
  output logic [paddr_width_p-1:0]   vec_a_ptr_o,
  output logic [paddr_width_p-1:0]   vec_b_ptr_o,
  output logic [len_width_p-1:0]     len_o,
  output logic [paddr_width_p-1:0]   res_ptr_o,
  input  logic                       done_i,
  input  logic [data_width_p-1:0]    result_i
);

  localparam logic [0:0] e_ready = 1'b0;
  localparam logic [0:0] e_resp  = 1'b1;

  logic [0:0]                 state_r;
  logic                       busy_r, done_r, start_r;
  logic [paddr_width_p-1:0]   vec_a_r, vec_b_r, res_ptr_r;
  logic [len_width_p-1:0]     len_r;
  logic [data_width_p-1:0]    result_r;

  logic [3:0]                 resp_type_p1;
  logic [paddr_width_p-1:0]   resp_addr_p1;
  logic [2:0]                 resp_size_p1;
  logic [data_width_p-1:0]    resp_data_p1;
  logic [payload_width_p-1:0] resp_payload_p1;

  logic [3:0]                 idx;
  logic                       accept, is_wr, is_rd, wr_fire;
  logic                       launch, zero_len_start, finish, clr_done, cfg_we;
  logic [data_width_p-1:0]    wdata_m, rdata;

  function automatic logic [data_width_p-1:0] mask_size(input logic [data_width_p-1:0] d,
                                                        input logic [2:0] sz);
    logic [data_width_p-1:0] m;
    for (int i = 0; i < data_width_p; i++) m[i] = (i < (8 << int'(sz)));
    return d & m;
  endfunction

  assign io_cmd_ready_o = (state_r == e_ready) & ~reset_i;
  assign io_resp_v_o    = (state_r == e_resp);
  assign accept         = io_cmd_v_i & io_cmd_ready_o;
  assign idx            = io_cmd_addr_i[6:3];
  assign is_wr          = (io_cmd_type_i == 4'd1) | (io_cmd_type_i == 4'd3);
  assign is_rd          = (io_cmd_type_i == 4'd0) | (io_cmd_type_i == 4'd2);
  assign wr_fire        = accept & is_wr;
  assign wdata_m        = mask_size(io_cmd_data_i, io_cmd_size_i);

  // Config is frozen while the datapath runs; start while busy is swallowed.
  assign cfg_we         = wr_fire & ~busy_r;
  assign launch         = cfg_we & (idx == 4'd4) & (len_r != '0);
  assign zero_len_start = cfg_we & (idx == 4'd4) & (len_r == '0);
  assign finish         = done_i & busy_r;
  assign clr_done       = wr_fire & (idx == 4'd7) & wdata_m[0];

`ifdef BP_CACC_CSR_CYCLE_COUNT_EN
  logic [data_width_p-1:0] cycle_cnt_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                              cycle_cnt_r <= '0;
    else if (launch)                          cycle_cnt_r <= '0;
    else if (busy_r && (cycle_cnt_r != '1))   cycle_cnt_r <= cycle_cnt_r + 1'b1;
  end
`endif

  always_comb begin
    rdata = '0;
    if (is_rd) begin
      case (idx)
        4'd0: rdata[paddr_width_p-1:0] = vec_a_r;
        4'd1: rdata[paddr_width_p-1:0] = vec_b_r;
        4'd2: rdata[len_width_p-1:0]   = len_r;
        4'd3: rdata[paddr_width_p-1:0] = res_ptr_r;
        4'd5: rdata[1:0]               = {done_r, busy_r};
        4'd6: rdata                    = result_r;
`ifdef BP_CACC_CSR_CYCLE_COUNT_EN
        4'd8: rdata                    = cycle_cnt_r;
`endif
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= e_ready;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      start_r   <= 1'b0;
      vec_a_r   <= '0;
      vec_b_r   <= '0;
      len_r     <= '0;
      res_ptr_r <= '0;
      result_r  <= '0;
    end else begin
      start_r <= launch;
      case (state_r)
        e_ready: if (accept)         state_r <= e_resp;
        default: if (io_resp_yumi_i) state_r <= e_ready;
      endcase
      // Completion outranks a same-cycle clear.
      if (finish) begin
        busy_r   <= 1'b0;
        done_r   <= 1'b1;
        result_r <= result_i;
      end else if (launch) begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end else if (zero_len_start) begin
        done_r <= 1'b1;
      end else if (clr_done) begin
        done_r <= 1'b0;
      end
      if (cfg_we) begin
        case (idx)
          4'd0:    vec_a_r   <= wdata_m[paddr_width_p-1:0];
          4'd1:    vec_b_r   <= wdata_m[paddr_width_p-1:0];
          4'd2:    len_r     <= wdata_m[len_width_p-1:0];
          4'd3:    res_ptr_r <= wdata_m[paddr_width_p-1:0];
          default: ;
        endcase
      end
    end
  end

  // Response stage: captured on acceptance, held until consumed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      resp_type_p1    <= io_cmd_type_i;
      resp_addr_p1    <= io_cmd_addr_i;
      resp_size_p1    <= io_cmd_size_i;
      resp_data_p1    <= rdata;
      resp_payload_p1 <= io_cmd_payload_i;
    end
  end

  assign io_resp_type_o    = resp_type_p1;
  assign io_resp_addr_o    = resp_addr_p1;
  assign io_resp_size_o    = resp_size_p1;
  assign io_resp_data_o    = resp_data_p1;
  assign io_resp_payload_o = resp_payload_p1;
  assign start_o           = start_r;
  assign vec_a_ptr_o       = vec_a_r;
  assign vec_b_ptr_o       = vec_b_r;
  assign len_o             = len_r;
  assign res_ptr_o         = res_ptr_r;

endmodule
